// File: rtl/data_path.sv
// data_path: single-cycle execution core with a 16 x WIDTH register file,
// a two-operand ALU with status flags, and a hex-to-seven-segment decoder.
//
// Modules in this file:
//   hexTo7Seg  - combinational nibble to seven-segment decoder
//                hex_input     [3:0] in   nibble to display
//                seven_seg_out [6:0] out  {g,f,e,d,c,b,a}, active-low
//   data_path  - execution core
//                clk           in   rising-edge clock
//                reset         in   asynchronous, active-low; clears the
//                                   register file, flags and rout
//                opCode [15:0] in   instruction word for this cycle
//                cin           in   carry-in for ADDC/ADDCI
//                flags  [4:0]  out  registered {F,C,L,Z,N}
//                rout   [W-1:0] out registered copy of last written value
//
// Instruction word: [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc;
// immediate forms carry imm8 in [7:0]. op 0000 is register-register and
// selects the operation through ext; other ops are immediate forms that
// reuse the same operation codes.
//
// Optional feature macro: DATAPATH_LOGIC_OPS_EN
//   defined   - AND/OR/XOR and ANDI/ORI/XORI execute
//   undefined - those encodings decode as NOPs and no logic unit is built

module hexTo7Seg (
  input  logic [3:0] hex_input,
  output logic [6:0] seven_seg_out
);

  always_comb begin
    seven_seg_out = 7'b1111111;
    case (hex_input)
      4'h0: seven_seg_out = 7'b1000000;
      4'h1: seven_seg_out = 7'b1111001;
      4'h2: seven_seg_out = 7'b0100100;
      4'h3: seven_seg_out = 7'b0110000;
      4'h4: seven_seg_out = 7'b0011001;
      4'h5: seven_seg_out = 7'b0010010;
      4'h6: seven_seg_out = 7'b0000010;
      4'h7: seven_seg_out = 7'b1111000;
      4'h8: seven_seg_out = 7'b0000000;
      4'h9: seven_seg_out = 7'b0010000;
      4'hA: seven_seg_out = 7'b0001000;
      4'hB: seven_seg_out = 7'b0000011;
      4'hC: seven_seg_out = 7'b1000110;
      4'hD: seven_seg_out = 7'b0100001;
      4'hE: seven_seg_out = 7'b0000110;
      4'hF: seven_seg_out = 7'b0001110;
      default: seven_seg_out = 7'b1111111;
    endcase
  end

endmodule

module data_path #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      opCode,
  input  logic             cin,
  output logic [4:0]       flags,
  output logic [WIDTH-1:0] rout
);

  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_ADDC = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_MOV  = 4'b1101;

  localparam int FLAG_F = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_L = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    K_NOP,
    K_ADD,
    K_SUB,
    K_CMP,
    K_MOV,
    K_LOG
  } kind_t;

  function automatic logic [WIDTH-1:0] sign_ext(input logic [7:0] imm);
    return {{(WIDTH-8){imm[7]}}, imm};
  endfunction

  function automatic logic [WIDTH-1:0] zero_ext(input logic [7:0] imm);
    return {{(WIDTH-8){1'b0}}, imm};
  endfunction

  // Two's-complement overflow: same-signed operands giving a result of the
  // other sign for addition; differently-signed operands whose result sign
  // departs from the minuend for subtraction.
  function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  logic [WIDTH-1:0] regs [16];

  logic [3:0]        op;
  logic [3:0]        rd_idx;
  logic [3:0]        ext;
  logic [3:0]        rs_idx;
  logic [7:0]        imm8;
  logic              is_rtype;
  logic [3:0]        sel;
  kind_t             kind;
  logic              use_cin;
  logic              sign_imm;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic signed [WIDTH-1:0] opa_s;
  logic signed [WIDTH-1:0] opb_s;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    diff;
  logic [WIDTH-1:0]  res;
  logic              wr_en;
  logic [4:0]        flags_nxt;

  // Decode: R-type takes its operation from ext, immediates from op.
  // Anything unlisted (including op 0000 with an unknown ext, or an
  // unknown word) falls to the default and becomes a NOP.
  always_comb begin
    op       = opCode[15:12];
    rd_idx   = opCode[11:8];
    ext      = opCode[7:4];
    rs_idx   = opCode[3:0];
    imm8     = opCode[7:0];
    is_rtype = (op == 4'b0000);
    sel      = is_rtype ? ext : op;
    kind     = K_NOP;
    use_cin  = 1'b0;
    sign_imm = 1'b0;
    case (sel)
      OP_ADD:  begin kind = K_ADD; sign_imm = 1'b1; end
      OP_ADDC: begin kind = K_ADD; sign_imm = 1'b1; use_cin = 1'b1; end
      OP_SUB:  begin kind = K_SUB; sign_imm = 1'b1; end
      OP_CMP:  begin kind = K_CMP; sign_imm = 1'b1; end
      OP_MOV:  kind = K_MOV;
`ifdef DATAPATH_LOGIC_OPS_EN
      OP_AND, OP_OR, OP_XOR: kind = K_LOG;
`endif
      default: kind = K_NOP;
    endcase
  end

  // Operand fetch: combinational register reads, so Rdest == Rsrc sees the
  // pre-edge value and a dependent instruction next cycle sees the update.
  always_comb begin
    opa = regs[rd_idx];
    if (is_rtype) begin
      opb = regs[rs_idx];
    end else if (sign_imm) begin
      opb = sign_ext(imm8);
    end else begin
      opb = zero_ext(imm8);
    end
    opa_s = opa;
    opb_s = opb;
    sum   = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, use_cin & cin};
    diff  = {1'b0, opa} - {1'b0, opb};
  end

  // Execute: result, write enable and next flag state. Flags not touched by
  // an operation keep their registered value.
  always_comb begin
    res       = '0;
    wr_en     = 1'b0;
    flags_nxt = flags;
    case (kind)
      K_ADD: begin
        res               = sum[WIDTH-1:0];
        wr_en             = 1'b1;
        flags_nxt[FLAG_C] = sum[WIDTH];
        flags_nxt[FLAG_F] = add_ovf(opa, opb, sum[WIDTH-1:0]);
        flags_nxt[FLAG_Z] = (sum[WIDTH-1:0] == '0);
        flags_nxt[FLAG_N] = sum[WIDTH-1];
      end
      K_SUB: begin
        res               = diff[WIDTH-1:0];
        wr_en             = 1'b1;
        // Bit WIDTH of the widened difference is the borrow.
        flags_nxt[FLAG_C] = diff[WIDTH];
        flags_nxt[FLAG_F] = sub_ovf(opa, opb, diff[WIDTH-1:0]);
        flags_nxt[FLAG_Z] = (diff[WIDTH-1:0] == '0);
        flags_nxt[FLAG_N] = diff[WIDTH-1];
      end
      K_CMP: begin
        flags_nxt[FLAG_Z] = (opa == opb);
        flags_nxt[FLAG_L] = (opa < opb);
        flags_nxt[FLAG_N] = (opa_s < opb_s);
      end
      K_MOV: begin
        res   = opb;
        wr_en = 1'b1;
      end
`ifdef DATAPATH_LOGIC_OPS_EN
      K_LOG: begin
        case (sel[1:0])
          2'b01:   res = opa & opb;
          2'b10:   res = opa | opb;
          default: res = opa ^ opb;
        endcase
        wr_en             = 1'b1;
        flags_nxt[FLAG_Z] = (res == '0);
        flags_nxt[FLAG_N] = res[WIDTH-1];
      end
`endif
      default: begin
        res       = '0;
        wr_en     = 1'b0;
        flags_nxt = flags;
      end
    endcase
  end

  // Writeback stage: register file, flags and rout update on one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
      flags <= '0;
      rout  <= '0;
    end else begin
      flags <= flags_nxt;
      if (wr_en) begin
        regs[rd_idx] <= res;
        rout         <= res;
      end
    end
  end

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;

  logic        clk;
  logic        reset;
  logic [15:0] opCode;
  logic        cin;
  logic [4:0]  flags;
  logic [15:0] rout;
  logic [3:0]  hex_input;
  logic [6:0]  seven_seg_out;

  int tests = 0;
  int fails = 0;

  data_path #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .opCode (opCode),
    .cin    (cin),
    .flags  (flags),
    .rout   (rout)
  );

  hexTo7Seg seg (
    .hex_input     (hex_input),
    .seven_seg_out (seven_seg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] C_AND  = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0101;
  localparam logic [3:0] C_ADDC = 4'b0111;
  localparam logic [3:0] C_SUB  = 4'b1001;
  localparam logic [3:0] C_CMP  = 4'b1011;
  localparam logic [3:0] C_MOV  = 4'b1101;

  typedef struct {
    logic [15:0] op;
    logic        c;
    logic [15:0] rout;
    logic [4:0]  flags;
  } vec_t;

  typedef struct {
    logic [15:0] rout;
    logic [4:0]  flags;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0] hex;
    logic [6:0] seg;
  } seg_vec_t;

  vec_t     vt[$];
  exp_t     sb[$];
  seg_vec_t st[16];

  function automatic logic [15:0] rr(input logic [3:0] ext, input logic [3:0] rd,
                                     input logic [3:0] rs);
    return {4'h0, rd, ext, rs};
  endfunction

  function automatic logic [15:0] ri(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic add_vec(input logic [15:0] op, input logic c,
                         input logic [15:0] r, input logic [4:0] f);
    vec_t v;
    v.op = op; v.c = c; v.rout = r; v.flags = f;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one instruction at the falling edge, queue its expected result,
  // and compare once the rising edge has written it back.
  task automatic issue(input logic [15:0] op, input logic c, input logic [15:0] er,
                       input logic [4:0] ef, input string nm);
    exp_t e;
    @(negedge clk);
    opCode = op;
    cin    = c;
    e.rout = er; e.flags = ef; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      check({e.name, " rout"}, {16'h0, rout}, {16'h0, e.rout});
      check({e.name, " flags"}, {27'h0, flags}, {27'h0, e.flags});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fib[16];
    logic [15:0] and_res;
    logic [15:0] and_out;

    // ---------------- seven-segment sweep ----------------
    st[0]  = '{4'h0, 7'b1000000}; st[1]  = '{4'h1, 7'b1111001};
    st[2]  = '{4'h2, 7'b0100100}; st[3]  = '{4'h3, 7'b0110000};
    st[4]  = '{4'h4, 7'b0011001}; st[5]  = '{4'h5, 7'b0010010};
    st[6]  = '{4'h6, 7'b0000010}; st[7]  = '{4'h7, 7'b1111000};
    st[8]  = '{4'h8, 7'b0000000}; st[9]  = '{4'h9, 7'b0010000};
    st[10] = '{4'hA, 7'b0001000}; st[11] = '{4'hB, 7'b0000011};
    st[12] = '{4'hC, 7'b1000110}; st[13] = '{4'hD, 7'b0100001};
    st[14] = '{4'hE, 7'b0000110}; st[15] = '{4'hF, 7'b0001110};
    for (int i = 0; i < 16; i++) begin
      hex_input = st[i].hex;
      #1;
      check($sformatf("seg%0h", i), {25'h0, seven_seg_out}, {25'h0, st[i].seg});
    end

    // ---------------- reset from time zero, ADD issued during reset ----------------
    reset  = 1'b0;
    cin    = 1'b0;
    opCode = rr(C_ADD, 4'd1, 4'd0);
    #1;
    check("reset rout", {16'h0, rout}, 32'h0);
    check("reset flags", {27'h0, flags}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("ADD in reset rout", {16'h0, rout}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- Fibonacci ----------------
    fib[0] = 1;
    fib[1] = 2;
    for (int n = 2; n < 16; n++) fib[n] = fib[n-1] + fib[n-2];
    issue(ri(C_ADD, 4'd0, 8'd1), 1'b0, 16'd1, 5'h00, "fib addi r0");
    issue(ri(C_ADD, 4'd1, 8'd1), 1'b0, 16'd1, 5'h00, "fib addi r1");
    issue(rr(C_ADD, 4'd1, 4'd0), 1'b0, 16'd2, 5'h00, "fib add r1");
    for (int n = 2; n < 16; n++) begin
      issue(rr(C_MOV, 4'(n), 4'(n-1)), 1'b0, 16'(fib[n-1]), 5'h00,
            $sformatf("fib mov r%0d", n));
      issue(rr(C_ADD, 4'(n), 4'(n-2)), 1'b0, 16'(fib[n]), 5'h00,
            $sformatf("fib add r%0d", n));
    end
    check("fib final", {16'h0, rout}, 32'h063D);
    issue(rr(C_MOV, 4'd14, 4'd14), 1'b0, 16'd987, 5'h00, "fib r14");

    // ---------------- asynchronous reset mid-cycle, in-flight discarded ----------------
    @(negedge clk);
    opCode = rr(C_ADD, 4'd15, 4'd14);
    #1;
    reset = 1'b0;
    #1;
    check("async rst rout", {16'h0, rout}, 32'h0);
    check("async rst flags", {27'h0, flags}, 32'h0);
    @(posedge clk);
    #1;
    check("rst hold rout", {16'h0, rout}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- table-driven vectors ----------------
    add_vec(ri(C_ADD, 4'd0, 8'd1),     1'b0, 16'h0001, 5'h00); // r0 cleared by reset
    add_vec(rr(C_MOV, 4'd15, 4'd15),   1'b0, 16'h0000, 5'h00); // r15 cleared
    add_vec(ri(C_MOV, 4'd1, 8'h7F),    1'b0, 16'h007F, 5'h00);
    add_vec(rr(C_ADD, 4'd1, 4'd1),     1'b0, 16'h00FE, 5'h00);
    add_vec(rr(C_ADD, 4'd1, 4'd1),     1'b0, 16'h01FC, 5'h00);
    add_vec(rr(C_ADD, 4'd1, 4'd1),     1'b0, 16'h03F8, 5'h00);
    add_vec(rr(C_ADD, 4'd1, 4'd1),     1'b0, 16'h07F0, 5'h00);
    add_vec(rr(C_ADD, 4'd1, 4'd1),     1'b0, 16'h0FE0, 5'h00);
    add_vec(rr(C_ADD, 4'd1, 4'd1),     1'b0, 16'h1FC0, 5'h00);
    add_vec(rr(C_ADD, 4'd1, 4'd1),     1'b0, 16'h3F80, 5'h00);
    add_vec(rr(C_ADD, 4'd1, 4'd1),     1'b0, 16'h7F00, 5'h00);
    add_vec(ri(C_MOV, 4'd2, 8'hFF),    1'b0, 16'h00FF, 5'h00);
    add_vec(rr(C_ADD, 4'd1, 4'd2),     1'b0, 16'h7FFF, 5'h00);
    add_vec(ri(C_ADD, 4'd1, 8'h01),    1'b0, 16'h8000, 5'h11); // F,N
    add_vec(ri(C_SUB, 4'd1, 8'h01),    1'b0, 16'h7FFF, 5'h10); // F
    add_vec(ri(C_ADD, 4'd3, 8'hFF),    1'b0, 16'hFFFF, 5'h01); // C=0
    add_vec(ri(C_ADD, 4'd3, 8'hFF),    1'b0, 16'hFFFE, 5'h09); // C,N
    add_vec(ri(C_ADD, 4'd5, 8'hFF),    1'b0, 16'hFFFF, 5'h01);
    add_vec(rr(C_ADDC, 4'd5, 4'd6),    1'b1, 16'h0000, 5'h0A); // C,Z
    add_vec(ri(C_ADDC, 4'd6, 8'h01),   1'b1, 16'h0002, 5'h00);
    add_vec(ri(C_MOV, 4'd7, 8'h03),    1'b0, 16'h0003, 5'h00);
    add_vec(rr(C_SUB, 4'd7, 4'd6),     1'b0, 16'h0001, 5'h00);
    add_vec(rr(C_SUB, 4'd7, 4'd7),     1'b0, 16'h0000, 5'h02); // Z
    add_vec(ri(C_SUB, 4'd7, 8'h01),    1'b0, 16'hFFFF, 5'h09); // borrow,N
    add_vec(ri(C_ADD, 4'd3, 8'h01),    1'b0, 16'hFFFF, 5'h01);
    add_vec(ri(C_MOV, 4'd2, 8'h05),    1'b0, 16'h0005, 5'h01); // flags kept
    add_vec(rr(C_CMP, 4'd2, 4'd3),     1'b0, 16'h0005, 5'h04); // L only
    add_vec(ri(C_ADD, 4'd0, 8'h00),    1'b0, 16'h0001, 5'h04); // L kept
    add_vec(rr(C_MOV, 4'd2, 4'd2),     1'b0, 16'h0005, 5'h04);
    add_vec(rr(C_MOV, 4'd3, 4'd3),     1'b0, 16'hFFFF, 5'h04);
    add_vec(ri(C_CMP, 4'd3, 8'hFF),    1'b0, 16'hFFFF, 5'h02); // equal
    add_vec(rr(C_CMP, 4'd3, 4'd2),     1'b0, 16'hFFFF, 5'h01); // signed less
    add_vec(ri(C_MOV, 4'd4, 8'hFF),    1'b0, 16'h00FF, 5'h01);
    add_vec(ri(C_ADD, 4'd4, 8'hFF),    1'b0, 16'h00FE, 5'h08);
`ifdef DATAPATH_LOGIC_OPS_EN
    and_res = 16'h000E;
    and_out = 16'h000E;
`else
    and_res = 16'h00FE;
    and_out = 16'h00FE;
`endif
    add_vec(ri(C_AND, 4'd4, 8'h0F),    1'b0, and_out, 5'h08);
    add_vec(rr(C_MOV, 4'd4, 4'd4),     1'b0, and_res, 5'h08);
    add_vec(16'h0000,                  1'b0, and_res, 5'h08); // NOP
    add_vec(16'h00F1,                  1'b0, and_res, 5'h08); // undefined ext
    add_vec(16'hE123,                  1'b0, and_res, 5'h08); // undefined op
    add_vec(16'hxxxx,                  1'b0, and_res, 5'h08); // unknown word
    add_vec(ri(C_ADD, 4'd8, 8'h80),    1'b0, 16'hFF80, 5'h01); // sign extend
    add_vec(ri(C_MOV, 4'd9, 8'h80),    1'b0, 16'h0080, 5'h01); // zero extend
    add_vec(rr(C_ADD, 4'd3, 4'd3),     1'b0, 16'hFFFE, 5'h09); // doubling

    for (int i = 0; i < vt.size(); i++) begin
      issue(vt[i].op, vt[i].c, vt[i].rout, vt[i].flags, $sformatf("vec%0d", i));
    end

    check("scoreboard drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_path.md
# data_path

Single-cycle 16-bit execution core: a 16 × 16-bit register file, a two-operand ALU with status flags, and a 4-bit hex-to-seven-segment decoder (`hexTo7Seg`) for display. A sequencer drives one instruction word per clock on `opCode`. The core executes it and writes the result to the destination register on the next rising edge. The written value appears on `rout`, which the board splits into four `hexTo7Seg` digits.

## Interface
Parameters:
- `WIDTH`, default 16, data and register width (instruction stays 16 bits).

Ports of `datapath`:
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low. Clears all registers, `flags` and `rout`.
- `opCode` input 16: instruction word for this cycle.
- `cin` input 1: carry-in used by ADDC/ADDCI.
- `flags` output 5: registered status `{F,C,L,Z,N}` = bits [4:0]. Bit 3 is carry.
- `rout` output 16: registered copy of the last value written to a register.

Ports of `hexTo7Seg` (combinational):
- `hex_input` input 4: nibble.
- `seven_seg_out` output 7: `{g,f,e,d,c,b,a}`, active-low.

## Operation
- Instruction fields:
  - [15:12] op; [11:8] Rdest; [7:4] ext; [3:0] Rsrc.
  - For immediate forms, [7:0] is imm8.
- R-type (op=0000), selected by ext:
  - 0101 ADD, 0111 ADDC, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV.
- Immediate forms use the same code in op: ADDI 0101, ADDCI 0111, SUBI 1001, CMPI 1011, ANDI 0001, ORI 0010, XORI 0011, MOVI 1101.
- Immediate extension: ADDI/ADDCI/SUBI/CMPI sign-extend imm8. ANDI/ORI/XORI/MOVI zero-extend.
- Results:
  - ADD: Rdest = Rdest + Rsrc.
  - ADDC: Rdest = Rdest + Rsrc + `cin`.
  - SUB: Rdest = Rdest − Rsrc.
  - MOV: Rdest = Rsrc.
  - Logic ops: bitwise. Immediate forms substitute the extended immediate for Rsrc.
- CMP/CMPI write no register. They evaluate Rdest − operand and set:
  - Z = equal.
  - L = Rdest < operand, unsigned.
  - N = Rdest < operand, signed.
  - C and F are unchanged.
- Flag rules:
  - ADD/ADDC/SUB and their immediates set C (carry out, or borrow for SUB), F (signed overflow), Z, and N (bit 15). L is unchanged.
  - Logic ops set Z and N only.
  - MOV/MOVI leave all flags unchanged.
- Arithmetic is modulo 2^16, with no saturation.
- Any other encoding, including op 0000 with an undefined ext, is a NOP: no write, and `flags`/`rout` hold. An all-X word is also treated as a NOP.
- Rdest == Rsrc is legal and reads the pre-edge value (e.g. ADD r3,r3 doubles r3).
- r0 is an ordinary writable register.

## Timing
- Register file reads are combinational. The write, `flags` update and `rout` update all occur on the same rising edge.
- Latency: `rout` shows an instruction's result one edge after `opCode` is applied.
- Back-to-back dependent instructions need no stall. The next cycle reads the updated register.
- Reset:
  - Asynchronous assertion clears r0–r15, `flags`=0 and `rout`=0 immediately.
  - While `reset` is low, instructions are ignored.
  - Execution resumes on the first rising edge after release.
  - Reset mid-program discards the in-flight instruction.
- `hexTo7Seg` has zero latency. Codes 0–F:
  - 0–7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.
  - 8–F: 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.

## Configuration
- `DATAPATH_LOGIC_OPS_EN`:
  - Defined: AND/OR/XOR and ANDI/ORI/XORI execute as specified.
  - Undefined: those six encodings decode as NOPs and the logic unit is not synthesized. All other behaviour is identical.

## Test plan
- Reset: pulse `reset` low mid-cycle -> `rout`=0x0000 and `flags`=0 immediately, with no clock needed. An ADD issued during reset has no effect.
- Fibonacci:
  - Sequence: ADDI r0,1; ADDI r1,1; ADD r1,r0; then alternating MOV r(n)←r(n−1) and ADD r(n),r(n−2) up to r15.
  - Required: `rout` steps through 1,1,2,2,3,3,5 … and ends at 0x063D (1597); r14 = 987.
- Carry/overflow:
  - r1=0x7FFF, ADDI r1,1 -> 0x8000 with F=1, N=1, C=0.
  - Then ADDI r1,−1 repeated from 0x0000 -> 0xFFFF with C=0.
  - ADDC with `cin`=1 on 0xFFFF+0x0000 -> 0x0000 with C=1, Z=1.
- CMP: r2=5, r3=0xFFFF, CMP r2,r3 -> L=1, N=0, Z=0. Neither register changes, and `rout` holds its previous value.
- Immediate extension:
  - MOVI r4,0xFF -> 0x00FF.
  - ADDI r4,0xFF -> 0x00FE.
  - With `DATAPATH_LOGIC_OPS_EN` undefined, ANDI r4,0x0F -> r4 unchanged.
- Display: sweep `hex_input` 0–F -> each output equals the listed code, e.g. 0x2 -> 0100100 and 0xD -> 0100001.
